// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port word memory, one access per 3 cycles.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; default build is fixed CPU priority.
module mem_arbiter #(
   parameter int unsigned SCREEN_BASE = 16384,
   parameter int unsigned KBD_ADDR    = 24576
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [14:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ack,
   output logic        cpu_err,
   output logic [15:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [14:0] dma_addr,
   input  logic [15:0] dma_wdata,
   output logic        dma_ack,
   output logic        dma_err,
   output logic [15:0] dma_rdata,
   output logic [14:0] mem_address,
   output logic [15:0] mem_in,
   output logic        mem_load,
   input  logic [15:0] mem_out,
   output logic        busy,
   output logic        owner
);
   localparam int unsigned AW = 15;
   localparam int unsigned DW = 16;
   localparam logic [AW-1:0] SCR = AW'(SCREEN_BASE);
   localparam logic [AW-1:0] KBD = AW'(KBD_ADDR);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t          state, state_nx;
   logic            pick_dma;
   logic            grant_we;
   logic [AW-1:0]   grant_addr;
   logic [DW-1:0]   grant_wdata;
   logic            grant_ram;
   logic            lat_we;
   logic            acc_err;

   // Arbitration between simultaneous requests
   always_comb begin
      pick_dma = 1'b0;
`ifdef MEM_ARBITER_RR_EN
      if (cpu_req && dma_req) pick_dma = ~owner;
      else                    pick_dma = dma_req;
`else
      pick_dma = ~cpu_req & dma_req;
`endif
   end

   // Fields of the winning requester; data and screen ranges behave identically
   always_comb begin
      grant_we    = pick_dma ? dma_we    : cpu_we;
      grant_addr  = pick_dma ? dma_addr  : cpu_addr;
      grant_wdata = pick_dma ? dma_wdata : cpu_wdata;
      grant_ram   = (grant_addr < SCR) || ((grant_addr >= SCR) && (grant_addr < KBD));
   end

   // Out-of-range access, or a write aimed at the read-only keyboard word
   always_comb begin
      acc_err = (mem_address > KBD) || (lat_we && (mem_address == KBD));
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (cpu_req || dma_req) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         owner       <= 1'b0;
         lat_we      <= 1'b0;
         mem_address <= '0;
         mem_in      <= '0;
         mem_load    <= 1'b0;
         cpu_ack     <= 1'b0;
         cpu_err     <= 1'b0;
         cpu_rdata   <= '0;
         dma_ack     <= 1'b0;
         dma_err     <= 1'b0;
         dma_rdata   <= '0;
      end else begin
         state    <= state_nx;
         busy     <= (state_nx != IDLE);
         mem_load <= 1'b0;
         cpu_ack  <= 1'b0;
         cpu_err  <= 1'b0;
         dma_ack  <= 1'b0;
         dma_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (state_nx == ACCESS) begin
                  owner       <= pick_dma;
                  lat_we      <= grant_we;
                  mem_address <= grant_addr;
                  mem_in      <= grant_wdata;
                  mem_load    <= grant_we && grant_ram;
               end
            end
            ACCESS: begin
               if (owner) begin
                  dma_rdata <= mem_out;
                  dma_ack   <= 1'b1;
                  dma_err   <= acc_err;
               end else begin
                  cpu_rdata <= mem_out;
                  cpu_ack   <= 1'b1;
                  cpu_err   <= acc_err;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed expectations for the listed scenarios.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int unsigned KBD = 24576;

   logic        clk;
   logic        rst_n;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [14:0] cpu_addr, dma_addr;
   logic [15:0] cpu_wdata, dma_wdata;
   logic        cpu_ack, cpu_err, dma_ack, dma_err;
   logic [15:0] cpu_rdata, dma_rdata;
   logic [14:0] mem_address;
   logic [15:0] mem_in, mem_out;
   logic        mem_load, busy, owner;

   int checks   = 0;
   int failures = 0;
   int load_cnt = 0;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
      .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out),
      .busy(busy), .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical memory attached to the DUT pins: falling-edge write and registered read
   logic [15:0] phys [0:32767];
   always @(negedge clk) begin
      if (mem_load === 1'b1) phys[mem_address] <= mem_in;
      mem_out <= phys[mem_address];
   end

   always @(negedge clk) if (mem_load === 1'b1) load_cnt++;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted transaction occupies the memory for the cycle after its grant
   // and is answered in the cycle after that; m_phase counts cycles since the grant (0 = free).
   logic [15:0] ref_mem [0:32767];
   bit          m_valid = 0;
   int          m_phase;
   bit          m_dma, m_owner, m_we;
   logic [14:0] m_addr;
   logic [15:0] m_wdata, e_cpu_rd, e_dma_rd;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1; m_phase = 0; m_owner = 0; m_dma = 0; m_we = 0;
         m_addr = '0; m_wdata = '0; e_cpu_rd = '0; e_dma_rd = '0;
      end else if (m_valid) begin
         if (m_phase == 0) begin
            if (cpu_req || dma_req) begin
`ifdef MEM_ARBITER_RR_EN
               m_dma = (cpu_req && dma_req) ? !m_owner : dma_req;
`else
               m_dma = !cpu_req;
`endif
               m_owner = m_dma;
               m_we    = m_dma ? dma_we    : cpu_we;
               m_addr  = m_dma ? dma_addr  : cpu_addr;
               m_wdata = m_dma ? dma_wdata : cpu_wdata;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (m_dma) e_dma_rd = ref_mem[m_addr];
            else       e_cpu_rd = ref_mem[m_addr];
            if (m_we && (int'(m_addr) < KBD)) ref_mem[m_addr] = m_wdata;
            m_phase = 2;
         end else begin
            m_phase = 0;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (m_valid) begin
         logic e_err;
         e_err = (m_phase == 2) && ((int'(m_addr) > KBD) || (m_we && int'(m_addr) == KBD));
         check("busy",      16'(busy),     16'(m_phase != 0));
         check("owner",     16'(owner),    16'(m_owner));
         check("mem_load",  16'(mem_load), 16'((m_phase == 1) && m_we && (int'(m_addr) < KBD)));
         check("mem_addr",  16'(mem_address), 16'(m_addr));
         check("mem_in",    mem_in,        m_wdata);
         check("cpu_ack",   16'(cpu_ack),  16'((m_phase == 2) && !m_dma));
         check("dma_ack",   16'(dma_ack),  16'((m_phase == 2) && m_dma));
         check("cpu_err",   16'(cpu_err),  16'(e_err && !m_dma));
         check("dma_err",   16'(dma_err),  16'(e_err && m_dma));
         check("cpu_rdata", cpu_rdata,     e_cpu_rd);
         check("dma_rdata", dma_rdata,     e_dma_rd);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One complete access on one port; returns data, error and cycles until ack
   task automatic access(input bit dma, input bit we, input logic [14:0] addr, input logic [15:0] data,
                         output logic [15:0] rd, output logic err, output int cyc);
      bit got;
      @(posedge clk);
      #2;
      if (dma) begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = data; end
      else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = data; end
      got = 0; cyc = 0; rd = 'x; err = 'x;
      while (!got && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (dma ? dma_ack : cpu_ack) begin
            got = 1;
            rd  = dma ? dma_rdata : cpu_rdata;
            err = dma ? dma_err   : cpu_err;
         end
      end
      cpu_req = 0; dma_req = 0;
      check("ack_seen", 16'(got), 16'd1);
   endtask

   logic [15:0] rd;
   logic        err;
   int          cyc;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32768; i++) begin phys[i] = '0; ref_mem[i] = '0; end
      rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy",  16'(busy),  16'd0);
      check("rst_owner", 16'(owner), 16'd0);
      check("rst_cpu_rdata", cpu_rdata, 16'h0000);
      rst_n = 1;

      // CPU write then read back, single mem_load pulse
      load_cnt = 0;
      access(0, 1, 15'd100, 16'hBEEF, rd, err, cyc);
      check("wr100_err", 16'(err), 16'd0);
      check("wr100_latency", 16'(cyc), 16'd3);
      access(0, 0, 15'd100, 16'h0000, rd, err, cyc);
      check("rd100_data", rd, 16'hBEEF);
      check("rd100_err", 16'(err), 16'd0);
      check("rd100_loads", 16'(load_cnt), 16'd1);

      // DMA write to screen base, CPU reads it; DMA reads data region
      access(1, 1, 15'd16384, 16'h00FF, rd, err, cyc);
      check("dmawr_err", 16'(err), 16'd0);
      access(0, 0, 15'd16384, 16'h0000, rd, err, cyc);
      check("rd16384_data", rd, 16'h00FF);
      access(1, 0, 15'd100, 16'h0000, rd, err, cyc);
      check("dmard100_data", rd, 16'hBEEF);
      access(1, 1, 15'd16383, 16'h1234, rd, err, cyc);
      access(0, 0, 15'd16383, 16'h0000, rd, err, cyc);
      check("rd16383_data", rd, 16'h1234);
      access(0, 1, 15'd24575, 16'hA5A5, rd, err, cyc);
      access(1, 0, 15'd24575, 16'h0000, rd, err, cyc);
      check("rd24575_data", rd, 16'hA5A5);

      // Keyboard and out-of-range boundaries
      load_cnt = 0;
      access(0, 1, 15'd24576, 16'h5555, rd, err, cyc);
      check("wrkbd_err", 16'(err), 16'd1);
      check("wrkbd_loads", 16'(load_cnt), 16'd0);
      access(0, 0, 15'd24576, 16'h0000, rd, err, cyc);
      check("rdkbd_err", 16'(err), 16'd0);
      check("rdkbd_data", rd, 16'h0000);
      access(0, 0, 15'd24577, 16'h0000, rd, err, cyc);
      check("rd24577_err", 16'(err), 16'd1);
      access(1, 1, 15'd32767, 16'h7777, rd, err, cyc);
      check("dmawr32767_err", 16'(err), 16'd1);
      check("dmawr32767_loads", 16'(load_cnt), 16'd0);

      // Both requesters held for six accesses
      do_reset();
      check("rst2_owner", 16'(owner), 16'd0);
      begin
         bit who [6];
         int n;
         @(posedge clk);
         #2;
         cpu_req = 1; cpu_we = 0; cpu_addr = 15'd100;
         dma_req = 1; dma_we = 0; dma_addr = 15'd16384;
         n = 0; cyc = 0;
         while (n < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cpu_ack || dma_ack) begin
               check("tie_one_ack", 16'(cpu_ack && dma_ack), 16'd0);
               who[n] = dma_ack;
               n++;
            end
         end
         cpu_req = 0; dma_req = 0;
         check("tie_count", 16'(n), 16'd6);
         check("tie_cycles", 16'(cyc), 16'd18);
         for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARBITER_RR_EN
            check($sformatf("tie_grant%0d", k), 16'(who[k]), 16'((k % 2) == 0));
`else
            check($sformatf("tie_grant%0d", k), 16'(who[k]), 16'd0);
`endif
         end
      end

      // Reset landing in the ACCESS cycle of a write
      @(posedge clk);
      #2;
      cpu_req = 1; cpu_we = 1; cpu_addr = 15'd300; cpu_wdata = 16'hDEAD;
      cyc = 0;
      while (mem_load !== 1'b1 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_found_access", 16'(mem_load), 16'd1);
      rst_n = 0; cpu_req = 0;
      @(negedge clk);
      check("abort_busy", 16'(busy), 16'd0);
      check("abort_load", 16'(mem_load), 16'd0);
      check("abort_ack",  16'(cpu_ack), 16'd0);
      rst_n = 1;
      access(0, 0, 15'd100, 16'h0000, rd, err, cyc);
      check("post_rst_latency", 16'(cyc), 16'd3);
      check("post_rst_data", rd, 16'hBEEF);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
